lc3_control_fsm: RTL and testbench

Instruction-sequencing control unit for the LC-3 CPU. It sits directly upstream of the datapath and drives every load, gate and mux-select control it consumes. It steps fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, and inserts a parameterised number of wait cycles around each SRAM access. It also drives the active-low memory strobes.

---
 rtl/lc3_control_fsm.sv | 244 ++++++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: instruction-sequencing control unit for the LC-3 CPU.
// It steps through fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR,
// LDR, STR and PAUSE. Each SRAM access state is held for MEM_WAIT cycles.
//
// Parameters
//   MEM_WAIT  cycles that each memory read/write state is held (1..15)
// Ports
//   Clk, Reset (sync, active-low)      clock and reset
//   Run, Continue                      start from Halted / resume from PAUSE
//   Opcode, IR_5, BEN                  decode inputs from the datapath
//   LD_*                               register load enables
//   Gate*                              bus drivers (at most one high per cycle)
//   PCMUX, ADDR2MUX, ADDR1MUX, SR1MUX,
//   SR2MUX, DRMUX, ALUK, MIO_EN        datapath mux selects
//   Mem_CE/UB/LB/OE/WE                 active-low SRAM strobes
module lc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic       ADDR1MUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       DRMUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [3:0] WaitLast = 4'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        StHalted,
        StS18, StS33, StS35, StS32,
        StS01, StS05, StS09,
        StS00, StS22,
        StS12,
        StS04, StS21,
        StS06, StS25, StS27,
        StS07, StS23, StS16,
        StPause1, StPause2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       wait_done;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StHalted;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign wait_done = (wait_q == WaitLast);

    // Next state. The wait counter is zero in every non-memory state, so it is
    // automatically cleared on entry to the next memory state.
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        unique case (state_q)
            StHalted: if (Run) state_d = StS18;
            StS18:    state_d = StS33;
            StS33: begin
                if (wait_done) state_d = StS35;
                else           wait_d  = wait_q + 4'd1;
            end
            StS35:    state_d = StS32;
            StS32: begin
                case (Opcode)
                    4'b0001: state_d = StS01;
                    4'b0101: state_d = StS05;
                    4'b1001: state_d = StS09;
                    4'b0000: state_d = StS00;
                    4'b1100: state_d = StS12;
                    4'b0100: state_d = StS04;
                    4'b0110: state_d = StS06;
                    4'b0111: state_d = StS07;
                    4'b1101: state_d = StPause1;
                    default: state_d = StS18; // unsupported opcode acts as NOP
                endcase
            end
            StS01, StS05, StS09, StS12: state_d = StS18;
            StS00:    state_d = BEN ? StS22 : StS18;
            StS22:    state_d = StS18;
            StS04:    state_d = StS21;
            StS21:    state_d = StS18;
            StS06:    state_d = StS25;
            StS25: begin
                if (wait_done) state_d = StS27;
                else           wait_d  = wait_q + 4'd1;
            end
            StS27:    state_d = StS18;
            StS07:    state_d = StS23;
            StS23:    state_d = StS16;
            StS16: begin
                if (wait_done) state_d = StS18;
                else           wait_d  = wait_q + 4'd1;
            end
            StPause1: if (Continue)  state_d = StPause2;
            StPause2: if (!Continue) state_d = StS18;
            default:  state_d = StHalted;
        endcase
    end

    // Moore output decode; SR2MUX in ADD/AND forwards IR_5 directly.
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ADDR1MUX   = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        DRMUX      = 1'b0;
        ALUK       = 2'b00;
        MIO_EN     = 1'b0;
        Mem_CE     = 1'b1;
        Mem_UB     = 1'b1;
        Mem_LB     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        unique case (state_q)
            StS18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = 2'b00;
                LD_PC  = 1'b1;
            end
            StS33, StS25: begin
                Mem_CE = 1'b0;
                Mem_UB = 1'b0;
                Mem_LB = 1'b0;
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = 1'b1;
            end
            StS35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            StS32: LD_BEN = 1'b1;
            StS01, StS05: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR_5;
                ALUK    = (state_q == StS05) ? 2'b01 : 2'b00;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StS09: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b10;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StS22: begin
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            StS12: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            StS04: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            StS21: begin
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            StS06, StS07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            StS27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StS23: begin
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            StS16: begin
                Mem_CE = 1'b0;
                Mem_UB = 1'b0;
                Mem_LB = 1'b0;
                Mem_WE = 1'b0;
            end
            StPause1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
module tb_lc3_control_fsm;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, BEN;
    logic [3:0] Opcode;
    logic [27:0] cv_a, cv_b; // control vectors of MEM_WAIT=2 and MEM_WAIT=3 instances

    int checks = 0;
    int passes = 0;

    always #5 Clk = ~Clk;

    lc3_control_fsm #(.MEM_WAIT(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .BEN(BEN),
        .LD_MAR(cv_a[27]), .LD_MDR(cv_a[26]), .LD_IR(cv_a[25]), .LD_BEN(cv_a[24]),
        .LD_CC(cv_a[23]), .LD_REG(cv_a[22]), .LD_PC(cv_a[21]), .LD_LED(cv_a[20]),
        .GatePC(cv_a[19]), .GateMDR(cv_a[18]), .GateALU(cv_a[17]), .GateMARMUX(cv_a[16]),
        .PCMUX(cv_a[15:14]), .ADDR2MUX(cv_a[13:12]), .ADDR1MUX(cv_a[11]),
        .SR1MUX(cv_a[10]), .SR2MUX(cv_a[9]), .DRMUX(cv_a[8]), .ALUK(cv_a[7:6]),
        .MIO_EN(cv_a[5]), .Mem_CE(cv_a[4]), .Mem_UB(cv_a[3]), .Mem_LB(cv_a[2]),
        .Mem_OE(cv_a[1]), .Mem_WE(cv_a[0])
    );

    lc3_control_fsm #(.MEM_WAIT(3)) dut_b (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .BEN(BEN),
        .LD_MAR(cv_b[27]), .LD_MDR(cv_b[26]), .LD_IR(cv_b[25]), .LD_BEN(cv_b[24]),
        .LD_CC(cv_b[23]), .LD_REG(cv_b[22]), .LD_PC(cv_b[21]), .LD_LED(cv_b[20]),
        .GatePC(cv_b[19]), .GateMDR(cv_b[18]), .GateALU(cv_b[17]), .GateMARMUX(cv_b[16]),
        .PCMUX(cv_b[15:14]), .ADDR2MUX(cv_b[13:12]), .ADDR1MUX(cv_b[11]),
        .SR1MUX(cv_b[10]), .SR2MUX(cv_b[9]), .DRMUX(cv_b[8]), .ALUK(cv_b[7:6]),
        .MIO_EN(cv_b[5]), .Mem_CE(cv_b[4]), .Mem_UB(cv_b[3]), .Mem_LB(cv_b[2]),
        .Mem_OE(cv_b[1]), .Mem_WE(cv_b[0])
    );

    // ld: MAR MDR IR BEN CC REG PC LED; gate: PC MDR ALU MARMUX; mem: CE UB LB OE WE
    function automatic logic [27:0] mk(input logic [7:0] ld, input logic [3:0] gate,
                                       input logic [1:0] pcmux, input logic [1:0] a2,
                                       input logic a1, input logic sr1, input logic sr2,
                                       input logic dr, input logic [1:0] aluk,
                                       input logic mio, input logic [4:0] mem);
        return {ld, gate, pcmux, a2, a1, sr1, sr2, dr, aluk, mio, mem};
    endfunction

    logic [27:0] e_idle, e_s18, e_rd, e_s35, e_s32, e_s01, e_s22, e_s07, e_s23, e_s16;
    logic [27:0] e_s06, e_p1;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Step through S33 x mw, S35, S32 on the chosen instance.
    task automatic fetch(input string tag, input int mw, input bit use_b);
        for (int i = 0; i < mw; i++) begin
            step();
            check({tag, " S33"}, use_b ? cv_b : cv_a, e_rd);
        end
        step();
        check({tag, " S35"}, use_b ? cv_b : cv_a, e_s35);
        step();
        check({tag, " S32"}, use_b ? cv_b : cv_a, e_s32);
    endtask

    initial begin
        e_idle = mk(8'h00, 4'h0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 5'b11111);
        e_s18  = mk(8'b1000_0010, 4'b1000, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 5'b11111);
        e_rd   = mk(8'b0100_0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 5'b00001);
        e_s35  = mk(8'b0010_0000, 4'b0100, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 5'b11111);
        e_s32  = mk(8'b0001_0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 5'b11111);
        e_s01  = mk(8'b0000_1100, 4'b0010, 2'b00, 2'b00, 0, 1, 1, 0, 2'b00, 0, 5'b11111);
        e_s22  = mk(8'b0000_0010, 4'b0000, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 0, 5'b11111);
        e_s07  = mk(8'b1000_0000, 4'b0001, 2'b00, 2'b01, 1, 1, 0, 0, 2'b00, 0, 5'b11111);
        e_s06  = e_s07;
        e_s23  = mk(8'b0100_0000, 4'b0010, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 0, 5'b11111);
        e_s16  = mk(8'h00, 4'h0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 5'b00010);
        e_p1   = mk(8'b0000_0001, 4'h0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 5'b11111);

        Reset = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0; IR_5 = 1'b0; BEN = 1'b0;
        step();
        step();
        check("reset a", cv_a, e_idle);
        check("reset b", cv_b, e_idle);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halted idle", cv_a, e_idle);
        end

        // ADD immediate on MEM_WAIT=2
        Opcode = 4'b0001; IR_5 = 1'b1; Run = 1'b1;
        step();
        check("add S18", cv_a, e_s18);
        Run = 1'b0;
        fetch("add", 2, 1'b0);
        step();
        check("add S01", cv_a, e_s01);
        step();
        check("add back S18", cv_a, e_s18);

        // BR not taken
        Opcode = 4'b0000; BEN = 1'b0; IR_5 = 1'b0;
        fetch("brn", 2, 1'b0);
        step();
        check("brn S00", cv_a, e_idle);
        step();
        check("brn S18", cv_a, e_s18);

        // BR taken
        BEN = 1'b1;
        fetch("brt", 2, 1'b0);
        step();
        check("brt S00", cv_a, e_idle);
        step();
        check("brt S22", cv_a, e_s22);
        step();
        check("brt S18", cv_a, e_s18);
        BEN = 1'b0;

        // PAUSE
        Opcode = 4'b1101;
        fetch("pause", 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("pause1 hold", cv_a, e_p1);
        end
        Continue = 1'b1;
        step();
        check("pause2", cv_a, e_idle);
        step();
        check("pause2 hold", cv_a, e_idle);
        Continue = 1'b0;
        step();
        check("pause exit S18", cv_a, e_s18);

        // Reset both, then STR on MEM_WAIT=3
        Reset = 1'b0;
        step();
        check("reset2 a", cv_a, e_idle);
        check("reset2 b", cv_b, e_idle);
        Reset = 1'b1;
        Opcode = 4'b0111; Run = 1'b1;
        step();
        check("str S18", cv_b, e_s18);
        Run = 1'b0;
        fetch("str", 3, 1'b1);
        step();
        check("str S07", cv_b, e_s07);
        step();
        check("str S23", cv_b, e_s23);
        for (int i = 0; i < 3; i++) begin
            step();
            check("str S16 we low", cv_b, e_s16);
        end
        step();
        check("str S18 after write", cv_b, e_s18);

        // LDR interrupted by reset in its second S25 cycle
        Opcode = 4'b0110;
        fetch("ldr", 3, 1'b1);
        step();
        check("ldr S06", cv_b, e_s06);
        step();
        check("ldr S25 w0", cv_b, e_rd);
        step();
        check("ldr S25 w1", cv_b, e_rd);
        Reset = 1'b0;
        step();
        check("ldr reset halted", cv_b, e_idle);
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ldr no reg load", cv_b, e_idle);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
